demux_1to8_b32: RTL and testbench
=================================

# demux_1to8_b32

Registered 1-to-8 demultiplexer for 32-bit words: the steering counterpart of the datapath's 8-to-1 select muxes. It accepts one word per cycle on a valid/ready input, routes it by a 3-bit select into one of eight single-entry output lanes, and holds each word until that lane's consumer accepts it. It sits between a single producer, such as a write-back or result bus, and eight independent consumers.

## Interface
- None. Data width (32) and lane count (8) are fixed by the module name.

- clk  input  1  rising-edge clock; the block's only clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  producer has a word on in_data/sel
- in_ready  output  1  block will accept the word this cycle
- sel  input  3  destination lane 0..7 (sel[2] is the MSB)
- in_data  input  32  word to route
- out_valid  output  8  bit k set: lane k holds a word
- out_ready  input  8  bit k set: consumer k takes lane k's word this cycle
- out_data  output  256  lane k word at out_data[32k+31:32k]
- accept_count  output  16  number of input words accepted since reset

## Operation
- Per-lane state: one 32-bit holding register plus one valid bit. Each lane is either EMPTY (valid=0) or FULL (valid=1).
- in_ready = !reset && (!out_valid[sel] || out_ready[sel]). This is combinational from sel, out_valid and out_ready.
- in_ready does not depend on in_valid.
- Accept occurs when in_valid && in_ready. Lane sel loads in_data and becomes FULL at the clock edge. accept_count increments by 1 and wraps 0xFFFF -> 0x0000.
- Drain for lane k occurs when out_valid[k] && out_ready[k]. Lane k becomes EMPTY at the edge, unless it is reloaded in the same cycle.
- Simultaneous drain and accept on the same lane: the old word is consumed and the new word is loaded. The lane stays FULL. No bubble is inserted.
- Simultaneous drain of one lane and accept into another lane: both take effect independently.
- Multiple lanes may drain in the same cycle.
- Accept into a FULL, non-draining lane is blocked (in_ready=0). The producer must hold in_valid, sel and in_data stable until in_ready=1.
- out_data lane k changes only on an accept into lane k. It is stable while FULL and not draining.
- EMPTY lanes retain their last word. Consumers must qualify out_data with out_valid.
- sel and in_data are don't-care when in_valid=0. No state changes in that case.
- Reset state:
  - out_valid = 8'h00
  - out_data = 0
  - accept_count = 0
  - in_ready = 0 while reset is high
- Reset mid-operation: all FULL lanes are discarded. A word presented in the reset cycle is not accepted and not counted.

## Timing
- Input-to-output latency is 1 cycle. A word accepted at edge N is visible with out_valid[sel]=1 after edge N.
- A consumer can take it in the cycle following edge N.
- Throughput: 1 word/cycle sustained when the target lane is EMPTY or draining.
- Combinational paths:
  - sel -> in_ready
  - out_valid -> in_ready
  - out_ready -> in_ready
- No combinational path from in_valid or in_data to any output.
- All state elements are updated on the rising edge of clk only.

## Test plan
- Reset: hold reset for 2 cycles with in_valid=1, sel=3, in_data=0xDEADBEEF. Required after release: out_valid=0x00, accept_count=0, out_data=0, and in_ready=0 during reset.
- Fan-out: send 0x11111111*k to sel=k for k=0..7, with out_ready=0.
  - After 8 cycles: out_valid=0xFF, each lane k holds 0x11111111*k, accept_count=8.
  - A 9th word to sel=5 then sees in_ready=0, and lane 5 is unchanged.
- Same-lane pass-through: lane 2 is FULL with 0xAAAA0000, out_ready[2]=1, in_valid=1, sel=2, in_data=0xBBBB0000.
  - Required: in_ready=1, then next cycle out_valid[2]=1 with out_data lane 2 = 0xBBBB0000.
  - Sustained 10 cycles of this gives 10 accepts and no bubble.
- Cross-lane concurrency: lane 0 is FULL and draining while a word for sel=7 is accepted in the same cycle.
  - Next cycle: out_valid=0x80 with lane 7 data correct.
- Backpressure hold: lane 4 is FULL, out_ready=0 for 5 cycles, and the producer holds 0x12345678 to sel=4.
  - Required: in_ready=0 for the 5 cycles and lane 4 data unchanged.
  - Then assert out_ready[4]: the word is accepted that cycle and accept_count increments once.
- Counter wrap and mid-op reset: preload via 65535 accepts, then 1 more.
  - Required: accept_count=0x0000.
  - Then assert reset with 3 lanes FULL: required out_valid=0x00 and accept_count=0 on the next cycle.

Source files
------------

// File: rtl/demux_1to8_b32.sv
// demux_1to8_b32: registered 1-to-8 steering demux for 32-bit words.
// One valid/ready producer feeds eight single-entry holding lanes.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   in_valid     producer offers in_data for lane sel
//   in_ready     the offered word will be taken this cycle
//   sel[2:0]     destination lane
//   in_data      word to route
//   out_valid[k] lane k holds a word
//   out_ready[k] consumer k takes lane k's word this cycle
//   out_data     lane k word at [32k+31:32k]
//   accept_count words accepted since reset (wraps at 16 bits)
module demux_1to8_b32 (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   sel,
    input  logic [31:0]  in_data,
    output logic [7:0]   out_valid,
    input  logic [7:0]   out_ready,
    output logic [255:0] out_data,
    output logic [15:0]  accept_count
);

    logic [7:0]  valid_q;
    logic [7:0]  valid_d;
    logic [31:0] data_q [8];
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        accept;
    logic [7:0]  load;

    // A lane can take a new word if it is empty or being drained
    // in the same cycle, so pass-through needs no bubble.
    always_comb begin
        in_ready = !reset && (!valid_q[sel] || out_ready[sel]);
        accept   = in_valid && in_ready;
        load     = 8'h00;
        if (accept) begin
            load = 8'h01 << sel;
        end
        // Drain clears, load sets; load wins on the same lane.
        valid_d = (valid_q & ~out_ready) | load;
        cnt_d   = cnt_q + {15'd0, accept};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 8'h00;
            cnt_q   <= 16'h0000;
            for (int k = 0; k < 8; k++) begin
                data_q[k] <= 32'h0;
            end
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            for (int k = 0; k < 8; k++) begin
                if (load[k]) begin
                    data_q[k] <= in_data;
                end
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int k = 0; k < 8; k++) begin
            out_data[32*k +: 32] = data_q[k];
        end
    end

    assign out_valid    = valid_q;
    assign accept_count = cnt_q;

endmodule

// File: tb/tb_demux_1to8_b32.sv
// tb_demux_1to8_b32: directed and random checks of demux_1to8_b32
// against a lane-occupancy reference model.
module tb_demux_1to8_b32;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   sel;
    logic [31:0]  in_data;
    logic [7:0]   out_valid;
    logic [7:0]   out_ready;
    logic [255:0] out_data;
    logic [15:0]  accept_count;

    int checks = 0;
    int errors = 0;

    // reference model: which lanes are occupied, what they hold,
    // and how many words went in (modulo 2^16)
    bit          m_full [8];
    bit [31:0]   m_word [8];
    int unsigned m_cnt;

    demux_1to8_b32 dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .sel          (sel),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .accept_count (accept_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lane(input int k);
        return out_data[32*k +: 32];
    endfunction

    // One clock cycle: drive, check in_ready, advance model, clock,
    // then compare all registered outputs with the model.
    task automatic step(input logic v, input logic [2:0] s,
                        input logic [31:0] d, input logic [7:0] ord,
                        input logic rst);
        bit          exp_rdy;
        bit          takes;
        logic [7:0]  ev;
        logic [255:0] ed;
        in_valid  = v;
        sel       = s;
        in_data   = d;
        out_ready = ord;
        reset     = rst;
        #2;
        // a lane has room if it is vacant or its consumer is taking it
        exp_rdy = !rst && (!m_full[s] || ord[s]);
        chk("in_ready", {255'd0, in_ready}, {255'd0, exp_rdy});
        if (rst) begin
            for (int k = 0; k < 8; k++) begin
                m_full[k] = 0;
                m_word[k] = 0;
            end
            m_cnt = 0;
        end else begin
            takes = v && exp_rdy;
            for (int k = 0; k < 8; k++) begin
                if (ord[k]) m_full[k] = 0;
            end
            if (takes) begin
                m_full[s] = 1;
                m_word[s] = d;
                m_cnt     = (m_cnt + 1) % 65536;
            end
        end
        @(posedge clk);
        #1;
        ev = '0;
        ed = '0;
        for (int k = 0; k < 8; k++) begin
            ev[k]         = m_full[k];
            ed[32*k +: 32] = m_word[k];
        end
        chk("out_valid", {248'd0, out_valid}, {248'd0, ev});
        chk("out_data", out_data, ed);
        chk("accept_count", {240'd0, accept_count}, {240'd0, 16'(m_cnt)});
    endtask

    initial begin
        int c0;
        for (int k = 0; k < 8; k++) begin
            m_full[k] = 0;
            m_word[k] = 0;
        end
        m_cnt = 0;

        // reset with a word on the bus
        step(1, 3'd3, 32'hDEADBEEF, 8'h00, 1);
        step(1, 3'd3, 32'hDEADBEEF, 8'h00, 1);
        chk("rst_valid", {248'd0, out_valid}, 256'd0);
        chk("rst_data", out_data, 256'd0);
        chk("rst_cnt", {240'd0, accept_count}, 256'd0);

        // fan-out into every lane, no consumers
        for (int k = 0; k < 8; k++) begin
            step(1, 3'(k), 32'h11111111 * k, 8'h00, 0);
        end
        chk("fan_valid", {248'd0, out_valid}, {248'd0, 8'hFF});
        chk("fan_cnt", {240'd0, accept_count}, {240'd0, 16'd8});
        for (int k = 0; k < 8; k++) begin
            chk("fan_lane", {224'd0, lane(k)},
                {224'd0, 32'h11111111 * k});
        end
        step(1, 3'd5, 32'hCAFEF00D, 8'h00, 0);
        chk("blk_rdy", {255'd0, in_ready}, 256'd0);
        chk("blk_lane5", {224'd0, lane(5)}, {224'd0, 32'h55555555});
        chk("blk_cnt", {240'd0, accept_count}, {240'd0, 16'd8});

        // same-lane pass-through
        step(1, 3'd2, 32'hAAAA0000, 8'h04, 0);
        step(1, 3'd2, 32'hBBBB0000, 8'h04, 0);
        chk("pt_lane2", {224'd0, lane(2)}, {224'd0, 32'hBBBB0000});
        c0 = accept_count;
        for (int i = 0; i < 10; i++) begin
            step(1, 3'd2, 32'hBBBB0000 + i, 8'h04, 0);
        end
        chk("pt_accepts", {240'd0, accept_count},
            {240'd0, 16'(c0 + 10)});
        chk("pt_valid2", {255'd0, out_valid[2]}, {255'd0, 1'b1});

        // cross-lane: drain lane 0 while loading lane 7
        step(0, 3'd0, 32'h0, 8'hFF, 0);
        step(1, 3'd0, 32'h00C0FFEE, 8'h00, 0);
        step(1, 3'd7, 32'h77000077, 8'h01, 0);
        chk("x_valid", {248'd0, out_valid}, {248'd0, 8'h80});
        chk("x_lane7", {224'd0, lane(7)}, {224'd0, 32'h77000077});

        // backpressure hold on lane 4
        step(1, 3'd4, 32'h44440000, 8'h00, 0);
        c0 = accept_count;
        for (int i = 0; i < 5; i++) begin
            step(1, 3'd4, 32'h12345678, 8'h00, 0);
            chk("bp_lane4", {224'd0, lane(4)}, {224'd0, 32'h44440000});
        end
        step(1, 3'd4, 32'h12345678, 8'h10, 0);
        chk("bp_lane4_new", {224'd0, lane(4)}, {224'd0, 32'h12345678});
        chk("bp_cnt", {240'd0, accept_count}, {240'd0, 16'(c0 + 1)});

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom), 3'($urandom), $urandom,
                 8'($urandom), 1'($urandom_range(0, 49) == 0));
        end

        // counter wrap
        step(0, 3'd0, 32'h0, 8'h00, 1);
        for (int i = 0; i < 65535; i++) begin
            step(1, 3'($urandom), $urandom, 8'hFF, 0);
        end
        chk("wrap_ffff", {240'd0, accept_count}, {240'd0, 16'hFFFF});
        step(1, 3'd1, 32'h0BAD0BAD, 8'hFF, 0);
        chk("wrap_zero", {240'd0, accept_count}, 256'd0);

        // mid-operation reset with three full lanes
        step(0, 3'd0, 32'h0, 8'hFF, 0);
        step(1, 3'd1, 32'hA1A1A1A1, 8'h00, 0);
        step(1, 3'd3, 32'hA3A3A3A3, 8'h00, 0);
        step(1, 3'd6, 32'hA6A6A6A6, 8'h00, 0);
        chk("mid_pre", {248'd0, out_valid}, {248'd0, 8'h4A});
        step(1, 3'd2, 32'hFEEDFACE, 8'h00, 1);
        chk("mid_valid", {248'd0, out_valid}, 256'd0);
        chk("mid_cnt", {240'd0, accept_count}, 256'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
